// File: rtl/cache_refill.sv
// Line-fill engine: reads one 8-word line from main memory into the cache data RAM,
// then marks the line valid in the tag RAM and pulses done.
module cache_refill #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] CPU_addr,
  output logic [12:0] main_mem_addr,
  output logic        main_mem_re,
  input  logic [31:0] main_mem_dout,
  output logic        cache_data_we,
  output logic [8:0]  cache_data_addr,
  output logic [31:0] cache_data_din,
  output logic        cache_tag_we,
  output logic [5:0]  cache_tag_addr,
  output logic [21:0] cache_tag_din,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, TAG, DONE} state_t;

  state_t      state_q, state_d;
  // line_q holds CPU_addr[31:5]: [26:6] tag, [5:0] index, [9:0] memory line number
  logic [26:0] line_q, line_d;
  logic [2:0]  rd_cnt_q, rd_cnt_d;
  // Return pipe entries are {valid, word[2:0]}, aligned with main-memory read latency
  logic [3:0]  pipe_q [RD_LAT];
  logic [3:0]  pipe_d [RD_LAT];
  logic [3:0]  pipe_out;
  logic        unused_cpu_lo;

  assign unused_cpu_lo = ^CPU_addr[4:0];
  assign pipe_out      = pipe_q[RD_LAT-1];

  always_comb begin
    state_d         = state_q;
    line_d          = line_q;
    rd_cnt_d        = rd_cnt_q;
    main_mem_re     = 1'b0;
    main_mem_addr   = '0;
    cache_data_we   = 1'b0;
    cache_data_addr = '0;
    cache_data_din  = main_mem_dout;
    cache_tag_we    = 1'b0;
    cache_tag_addr  = '0;
    cache_tag_din   = '0;
    busy            = (state_q != IDLE);
    done            = 1'b0;

    pipe_d[0] = {state_q == FILL, rd_cnt_q};
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (pipe_out[3]) begin
      cache_data_we   = 1'b1;
      cache_data_addr = {line_q[5:0], pipe_out[2:0]};
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          line_d   = CPU_addr[31:5];
          rd_cnt_d = '0;
          state_d  = FILL;
        end
      end
      FILL: begin
        main_mem_re   = 1'b1;
        main_mem_addr = {line_q[9:0], rd_cnt_q};
        rd_cnt_d      = rd_cnt_q + 3'd1;
        if (rd_cnt_q == 3'd7) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Even at RD_LAT=1 the last word lands here, so the tag always follows it
        if (pipe_out[3] && (pipe_out[2:0] == 3'd7)) begin
          state_d = TAG;
        end
      end
      TAG: begin
        cache_tag_we   = 1'b1;
        cache_tag_addr = line_q[5:0];
        cache_tag_din  = {1'b1, line_q[26:6]};
        state_d        = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      line_q   <= '0;
      rd_cnt_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      rd_cnt_q <= rd_cnt_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: one instance at RD_LAT=1 and one at RD_LAT=3,
// each fed by a read-only main-memory model with the matching latency.
module tb_cache_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start3;
  logic [31:0] addr1, addr3;
  logic [12:0] ma1, ma3;
  logic        re1, re3;
  logic [31:0] dout1, dout3;
  logic        dwe1, dwe3;
  logic [8:0]  da1, da3;
  logic [31:0] din1, din3;
  logic        twe1, twe3;
  logic [5:0]  ta1, ta3;
  logic [21:0] td1, td3;
  logic        bz1, bz3, dn1, dn3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [54:0] obs_v, exp_v;
  logic [31:0] obs_din, exp_din;
  logic        exp_dwe;

  always #5 clk = ~clk;

  cache_refill #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .CPU_addr(addr1),
    .main_mem_addr(ma1), .main_mem_re(re1), .main_mem_dout(dout1),
    .cache_data_we(dwe1), .cache_data_addr(da1), .cache_data_din(din1),
    .cache_tag_we(twe1), .cache_tag_addr(ta1), .cache_tag_din(td1),
    .busy(bz1), .done(dn1)
  );

  cache_refill #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .CPU_addr(addr3),
    .main_mem_addr(ma3), .main_mem_re(re3), .main_mem_dout(dout3),
    .cache_data_we(dwe3), .cache_data_addr(da3), .cache_data_din(din3),
    .cache_tag_we(twe3), .cache_tag_addr(ta3), .cache_tag_din(td3),
    .busy(bz3), .done(dn3)
  );

  function automatic logic [31:0] memf(input logic [12:0] a);
    return {3'b101, a, 3'b010, ~a};
  endfunction

  // Memory model: word for the address issued in cycle n appears in cycle n+RD_LAT
  logic [12:0] a1_q;
  logic [12:0] a3_q [3];
  always @(posedge clk) begin
    a1_q    <= ma1;
    a3_q[0] <= ma3;
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
  end
  assign dout1 = memf(a1_q);
  assign dout3 = memf(a3_q[2]);

  task automatic sample(input int L);
    if (L == 1) begin
      obs_v   = {re1, ma1, dwe1, da1, twe1, ta1, td1, dn1, bz1};
      obs_din = din1;
    end else begin
      obs_v   = {re3, ma3, dwe3, da3, twe3, ta3, td3, dn3, bz3};
      obs_din = din3;
    end
  endtask

  // Expected outputs r cycles after the accepting edge (r<=0 or past DONE means idle)
  task automatic model(input int L, input logic [31:0] A, input int r);
    int w, dw;
    logic re, dwe, twe;
    logic [12:0] ma;
    logic [8:0]  da;
    logic [5:0]  ta;
    logic [21:0] td;
    w   = r - 1;
    dw  = r - 1 - L;
    re  = (r >= 1) && (r <= 8);
    dwe = (r >= 1 + L) && (r <= 8 + L);
    twe = (r == 9 + L);
    ma  = re  ? {A[14:5], w[2:0]}  : 13'd0;
    da  = dwe ? {A[10:5], dw[2:0]} : 9'd0;
    ta  = twe ? A[10:5] : 6'd0;
    td  = twe ? {1'b1, A[31:11]} : 22'd0;
    exp_v   = {re, ma, dwe, da, twe, ta, td, (r == 10 + L), (r >= 1) && (r <= 10 + L)};
    exp_dwe = dwe;
    exp_din = memf({A[14:5], dw[2:0]});
  endtask

  task automatic drive(input int L, input logic s, input logic [31:0] A);
    if (L == 1) begin
      start1 = s;
      addr1  = A;
    end else begin
      start3 = s;
      addr3  = A;
    end
  endtask

  // Present start in cycle 0; returns just after the accepting edge
  task automatic kick(input int L, input logic [31:0] A, input logic keep);
    @(negedge clk);
    drive(L, 1'b1, A);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (L == 1) start1 = 1'b0;
      else        start3 = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int L = 1; L <= 3; L += 2) begin
        sample(L);
        model(L, 32'h0, -1);
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL reset L%0d c%0d outputs got %h want %h", L, c, obs_v, exp_v);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic(input int L, input logic [31:0] A, input string tn);
    kick(L, A, 1'b0);
    for (int c = 1; c <= 10 + L + 2; c++) begin
      @(negedge clk);
      sample(L);
      model(L, A, c);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s c%0d outputs got %h want %h", tn, c, obs_v, exp_v);
      end
      if (exp_dwe) begin
        n_cmp++;
        if (obs_din !== exp_din) begin
          n_bad++;
          $display("FAIL %s c%0d din got %h want %h", tn, c, obs_din, exp_din);
        end
      end
    end
  endtask

  // Hand-computed anchors for the 0x1A60 line at RD_LAT=1
  task automatic test_anchor_1a60();
    kick(1, 32'h0000_1A60, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if (ma1 !== 13'd1688 || re1 !== 1'b1) begin
          n_bad++;
          $display("FAIL anchor c1 mem_addr got %0d re %b want 1688 re 1", ma1, re1);
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (ma1 !== 13'd1695) begin
          n_bad++;
          $display("FAIL anchor c8 mem_addr got %0d want 1695", ma1);
        end
      end
      if (c == 2 || c == 9) begin
        n_cmp++;
        if (da1 !== ((c == 2) ? 9'd152 : 9'd159) || dwe1 !== 1'b1) begin
          n_bad++;
          $display("FAIL anchor c%0d data_addr got %0d we %b", c, da1, dwe1);
        end
      end
      if (c == 10) begin
        n_cmp++;
        if (twe1 !== 1'b1 || ta1 !== 6'd19 || td1 !== 22'h200003) begin
          n_bad++;
          $display("FAIL anchor c10 tag got we %b addr %0d din %h want 1 19 200003", twe1, ta1, td1);
        end
      end
      if (c == 11 || c == 12) begin
        n_cmp++;
        if (dn1 !== (c == 11)) begin
          n_bad++;
          $display("FAIL anchor c%0d done got %b want %b", c, dn1, (c == 11));
        end
      end
    end
  endtask

  task automatic test_top_line();
    kick(1, 32'hFFFF_FFE0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 8) begin
        n_cmp++;
        if (ma1 !== 13'd8191) begin
          n_bad++;
          $display("FAIL top c8 mem_addr got %0d want 8191", ma1);
        end
      end
      if (c == 2 || c == 9) begin
        n_cmp++;
        if (da1 !== ((c == 2) ? 9'd504 : 9'd511)) begin
          n_bad++;
          $display("FAIL top c%0d data_addr got %0d", c, da1);
        end
      end
      if (c == 10) begin
        n_cmp++;
        if (ta1 !== 6'd63 || td1 !== 22'h3FFFFF) begin
          n_bad++;
          $display("FAIL top c10 tag got addr %0d din %h want 63 3fffff", ta1, td1);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_addr_change();
    logic [31:0] A;
    A = 32'h0000_1A60;
    kick(1, A, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      sample(1);
      model(1, A, c);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL addr_change c%0d outputs got %h want %h", c, obs_v, exp_v);
      end
      if (c == 2) addr1 = 32'h0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] A1, A2, Ae;
    int r;
    A1 = 32'h1234_5660;
    A2 = 32'h0ABC_D7A0;
    kick(1, A1, 1'b1);
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      r  = (c <= 12) ? c : c - 12;
      Ae = (c <= 12) ? A1 : A2;
      sample(1);
      model(1, Ae, r);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL back_to_back c%0d outputs got %h want %h", c, obs_v, exp_v);
      end
      if (c == 5)  addr1  = A2;
      if (c == 13) start1 = 1'b0;
    end
  endtask

  task automatic test_start_busy();
    logic [31:0] A;
    int ndone;
    A = 32'h0000_0420;
    ndone = 0;
    kick(1, A, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      sample(1);
      model(1, A, c);
      if (dn1 === 1'b1) ndone++;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL start_busy c%0d outputs got %h want %h", c, obs_v, exp_v);
      end
      if (c == 3) drive(1, 1'b1, 32'hDEAD_BEE0);
      if (c == 4) start1 = 1'b0;
    end
    n_cmp++;
    if (ndone !== 1) begin
      n_bad++;
      $display("FAIL start_busy done count got %0d want 1", ndone);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] A;
    A = 32'h0000_1A60;
    kick(1, A, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      sample(1);
      model(1, A, (c <= 5) ? c : -1);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL mid_reset c%0d outputs got %h want %h", c, obs_v, exp_v);
      end
      if (c == 5) rst = 1'b1;
      if (c == 6) rst = 1'b0;
    end
    test_basic(1, 32'h0000_3C40, "after_reset");
  endtask

  initial begin
    rst    = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    addr1  = '0;
    addr3  = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic(1, 32'h0000_1A60, "basic_l1");
    test_anchor_1a60();
    test_top_line();
    test_basic(1, 32'hFFFF_FFE0, "top_l1");
    test_addr_change();
    test_back_to_back();
    test_start_busy();
    test_mid_reset();
    test_basic(3, 32'h0000_1A60, "basic_l3");
    test_basic(3, 32'h8765_43E0, "mixed_l3");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
